// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: expands one AW/AR command into a per-beat address stream.
// Optional AXI_BURST_4K_CHECK_EN adds beat_err, flagging INCR bursts that cross a 4 KB page.
module axi_burst_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int ID_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ID_W-1:0]   beat_id,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [7:0]        beat_idx,
  output logic              beat_last,
`ifdef AXI_BURST_4K_CHECK_EN
  output logic              beat_err,
`endif
  output logic              busy
);

  localparam int MAX_SIZE = $clog2(DATA_BYTES);

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    if (s > 3'(MAX_SIZE)) return 3'(MAX_SIZE);
    return s;
  endfunction

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] s);
    return (a >> s) << s;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_bytes(input logic [2:0] s);
    return ADDR_W'(1) << s;
  endfunction

  state_t              state_q;
  mode_t               mode_q;
  logic                cmd_ready_q;
  logic                beat_valid_q;
  logic                busy_q;
  logic                last_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          idx_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [ADDR_W-1:0]   wrap_low_q;
  logic [ADDR_W-1:0]   wrap_span_q;
`ifdef AXI_BURST_4K_CHECK_EN
  logic                err_q;
  logic                err_d;
  logic [ADDR_W-1:0]   cap_end;
`endif

  mode_t               mode_d;
  logic [2:0]          size_d;
  logic [ADDR_W-1:0]   span_d;
  logic [ADDR_W-1:0]   low_d;
  logic [ADDR_W-1:0]   inc_addr;
  logic [ADDR_W-1:0]   addr_d;

  // Command decode: effective size, burst mode and wrap window for the capture edge
  always_comb begin
    size_d = clamp_size(cmd_size);
    span_d = (ADDR_W'(cmd_len) + ADDR_W'(1)) << size_d;
    low_d  = cmd_addr & ~(span_d - ADDR_W'(1));
    mode_d = MODE_INCR;
    case (cmd_burst)
      2'b00:   mode_d = MODE_FIXED;
      2'b10:   if (cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15)
                 mode_d = MODE_WRAP;
      default: mode_d = MODE_INCR;
    endcase
`ifdef AXI_BURST_4K_CHECK_EN
    cap_end = align_addr(cmd_addr, size_d) + span_d - ADDR_W'(1);
    err_d   = (mode_d == MODE_INCR) && (cap_end[ADDR_W-1:12] != cmd_addr[ADDR_W-1:12]);
`endif
  end

  // Next beat address from the current one; first beat may be unaligned
  always_comb begin
    inc_addr = align_addr(addr_q, size_q) + beat_bytes(size_q);
    addr_d   = inc_addr;
    case (mode_q)
      MODE_FIXED: addr_d = addr_q;
      MODE_WRAP:  if (inc_addr == wrap_low_q + wrap_span_q) addr_d = wrap_low_q;
      default:    addr_d = inc_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_FIXED;
      cmd_ready_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      last_q       <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      size_q       <= '0;
      wrap_low_q   <= '0;
      wrap_span_q  <= '0;
`ifdef AXI_BURST_4K_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            state_q      <= BURST;
            cmd_ready_q  <= 1'b0;
            beat_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            id_q         <= cmd_id;
            addr_q       <= cmd_addr;
            idx_q        <= '0;
            len_q        <= cmd_len;
            last_q       <= (cmd_len == 8'd0);
            size_q       <= size_d;
            mode_q       <= mode_d;
            wrap_low_q   <= low_d;
            wrap_span_q  <= span_d;
`ifdef AXI_BURST_4K_CHECK_EN
            err_q        <= err_d;
`endif
          end
        end
        BURST: begin
          if (beat_ready) begin
            if (last_q) begin
              state_q      <= IDLE;
              cmd_ready_q  <= 1'b1;
              beat_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              last_q       <= 1'b0;
`ifdef AXI_BURST_4K_CHECK_EN
              err_q        <= 1'b0;
`endif
            end else begin
              addr_q <= addr_d;
              idx_q  <= idx_q + 8'd1;
              last_q <= (idx_q + 8'd1 == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign beat_valid = beat_valid_q;
  assign beat_id    = id_q;
  assign beat_addr  = addr_q;
  assign beat_idx   = idx_q;
  assign beat_last  = last_q;
  assign busy       = busy_q;
`ifdef AXI_BURST_4K_CHECK_EN
  assign beat_err   = err_q;
`endif

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed bursts plus randomized bursts against
// an arithmetic address model (beat i computed directly from start address and burst rules).
module tb_axi_burst_addr_gen;
  localparam int ADDR_W     = 32;
  localparam int DATA_BYTES = 4;
  localparam int ID_W       = 4;
  localparam int MAX_SIZE   = 2;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic              beat_valid;
  logic              beat_ready;
  logic [ID_W-1:0]   beat_id;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        beat_idx;
  logic              beat_last;
  logic              busy;
`ifdef AXI_BURST_4K_CHECK_EN
  logic              beat_err;
`endif

  int tests = 0;
  int fails = 0;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_addr(beat_addr), .beat_idx(beat_idx), .beat_last(beat_last),
`ifdef AXI_BURST_4K_CHECK_EN
    .beat_err(beat_err),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wrap_legal(input int burst, input int len);
    return (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] addr, input int len,
                                             input int size, input int burst, input int i);
    int     sz = (size > MAX_SIZE) ? MAX_SIZE : size;
    longint b  = longint'(1) << sz;
    longint al = (longint'(addr) >> sz) << sz;
    longint t;
    longint low;
    if (i == 0 || burst == 0) return addr;
    if (wrap_legal(burst, len)) begin
      t   = b * (len + 1);
      low = (longint'(addr) / t) * t;
      return 32'(low + ((al - low + i * b) % t));
    end
    return 32'(al + i * b);
  endfunction

`ifdef AXI_BURST_4K_CHECK_EN
  function automatic logic model_err(input logic [31:0] addr, input int len,
                                     input int size, input int burst);
    int          sz = (size > MAX_SIZE) ? MAX_SIZE : size;
    longint      b  = longint'(1) << sz;
    longint      al = (longint'(addr) >> sz) << sz;
    logic [31:0] e;
    if (burst == 0 || wrap_legal(burst, len)) return 1'b0;
    e = 32'(al + b * (len + 1) - 1);
    return e[31:12] != addr[31:12];
  endfunction
`endif

  task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                           input int burst, input logic [3:0] id, input bit rnd,
                           input int stall_at);
    int i = 0;
    int stalls = 0;
    int rnd_stalls = 0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    cmd_size  = 3'(size);
    cmd_burst = 2'(burst);
    cmd_id    = id;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_len   = 8'($urandom);
    check("first_beat_valid", beat_valid, 1);
    while (i <= len) begin
      check("beat_valid", beat_valid, 1);
      check("busy", busy, 1);
      check("cmd_ready_burst", cmd_ready, 0);
      check("beat_addr", beat_addr, model_addr(addr, len, size, burst, i));
      check("beat_idx", beat_idx, 64'(i));
      check("beat_last", beat_last, 64'(i == len));
      check("beat_id", beat_id, id);
`ifdef AXI_BURST_4K_CHECK_EN
      check("beat_err", beat_err, model_err(addr, len, size, burst));
`endif
      if (i == stall_at && stalls < 3) begin
        beat_ready = 1'b0;
        cmd_valid  = 1'b1;
        cmd_addr   = 32'hDEAD_0000;
        stalls++;
      end else if (rnd && rnd_stalls < 8 && $urandom_range(0, 3) == 0) begin
        beat_ready = 1'b0;
        cmd_valid  = 1'b0;
        rnd_stalls++;
      end else begin
        beat_ready = 1'b1;
        cmd_valid  = 1'b0;
        rnd_stalls = 0;
      end
      @(negedge clk);
      if (beat_ready) i++;
    end
    cmd_valid = 1'b0;
    check("end_beat_valid", beat_valid, 0);
    check("end_busy", busy, 0);
    check("end_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int          len;
    int          burst;
    logic [31:0] addr;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_id     = '0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    beat_ready = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_beat_addr", beat_addr, 0);
    check("rst_beat_last", beat_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_burst(32'h0000_1000, 3, 2, 1, 4'h3, 1'b0, -1);
    run_burst(32'h0000_1008, 3, 2, 2, 4'h5, 1'b0, -1);
    run_burst(32'h0000_0020, 2, 2, 0, 4'h6, 1'b0, -1);
    run_burst(32'h0000_1003, 2, 2, 1, 4'h7, 1'b0, -1);
    run_burst(32'h0000_1000, 3, 2, 1, 4'h8, 1'b0, 1);
    run_burst(32'h0000_1004, 5, 2, 2, 4'h9, 1'b0, -1);
    run_burst(32'h0000_2000, 7, 7, 3, 4'hA, 1'b0, -1);
    run_burst(32'hFFFF_FFF8, 3, 2, 1, 4'hB, 1'b0, -1);

    // Reset in the middle of an 8-beat INCR burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_3000; cmd_len = 8'd7;
    cmd_size  = 3'd2; cmd_burst = 2'b01;       cmd_id  = 4'hC;
    @(negedge clk);
    cmd_valid  = 1'b0;
    beat_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_idx", beat_idx, 2);
    check("pre_rst_addr", beat_addr, 32'h0000_3008);
    rst = 1'b1;
    #1;
    check("mid_rst_beat_valid", beat_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready_low", cmd_ready, 0);
    run_burst(32'h0000_0040, 0, 2, 1, 4'hD, 1'b0, -1);

`ifdef AXI_BURST_4K_CHECK_EN
    run_burst(32'h0000_0FF8, 3, 2, 1, 4'h1, 1'b0, -1);
    run_burst(32'h0000_0FF0, 3, 2, 1, 4'h2, 1'b0, -1);
`endif

    run_burst(32'h0000_1F00, 255, 2, 1, 4'hE, 1'b1, -1);

    for (int n = 0; n < 40; n++) begin
      burst = int'($urandom_range(0, 3));
      if (burst == 2 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       len = 1;
          1:       len = 3;
          2:       len = 7;
          default: len = 15;
        endcase
      end else begin
        len = int'($urandom_range(0, 20));
      end
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
      run_burst(addr, len, int'($urandom_range(0, 7)), burst, 4'($urandom), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
